reg_file_scoreboard: RTL and testbench

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

---
 rtl/reg_file_scoreboard.sv | 103 ++++++++++
 tb/tb_reg_file_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write scoreboard.
// Two combinational read ports with write-through bypass, one write-back port,
// and an issue interlock driven by saturating-free pending counters.
module reg_file_scoreboard #(
   parameter int unsigned NREG = 16,
   parameter int unsigned CNTW = 3
) (
   input  logic                  clk,
   input  logic                  rest,
   input  logic                  Freze,
   input  logic                  RegWrite,
   input  logic [3:0]            Rd_In,
   input  logic [15:0]           WriteDataRegFile,
   input  logic [3:0]            Rs_Addr,
   input  logic [3:0]            Rt_Addr,
   output logic [15:0]           Rs_Data,
   output logic [15:0]           Rt_Data,
   input  logic                  Issue_Valid,
   input  logic                  Issue_RegWrite,
   input  logic [3:0]            Issue_Rd,
   output logic                  Stall,
   output logic [NREG-1:0]       Pending_Mask,
   output logic                  Sb_Error
);

   localparam logic [CNTW-1:0] CntMax = '1;

   logic [15:0]     regs_q [NREG];
   logic [CNTW-1:0] cnt_q  [NREG];
   logic            sb_error_q;

   logic retire;
   logic accept;
   logic rs_busy;
   logic rt_busy;
   logic rd_full;

   assign Sb_Error = sb_error_q;

   // Retire only counts when the pipeline actually advances and targets a real register.
   assign retire = RegWrite & ~Freze & (Rd_In != 4'd0);

   // Source is busy unless its last outstanding write retires this very cycle.
   always_comb begin
      rs_busy = (Rs_Addr != 4'd0) && (cnt_q[Rs_Addr] != '0) &&
                !(retire && (Rd_In == Rs_Addr) && (cnt_q[Rs_Addr] == CNTW'(1)));
      rt_busy = (Rt_Addr != 4'd0) && (cnt_q[Rt_Addr] != '0) &&
                !(retire && (Rd_In == Rt_Addr) && (cnt_q[Rt_Addr] == CNTW'(1)));
      rd_full = Issue_RegWrite && (Issue_Rd != 4'd0) && (cnt_q[Issue_Rd] == CntMax) &&
                !(retire && (Rd_In == Issue_Rd));
      Stall   = Issue_Valid & (rs_busy | rt_busy | rd_full);
      accept  = Issue_Valid & ~Stall & ~Freze & ~rest;
   end

   // Read ports: R0 is hardwired zero, in-flight write-back is forwarded.
   always_comb begin
      Rs_Data = '0;
      Rt_Data = '0;
      if (Rs_Addr != 4'd0) begin
         Rs_Data = (RegWrite && (Rd_In == Rs_Addr)) ? WriteDataRegFile : regs_q[Rs_Addr];
      end
      if (Rt_Addr != 4'd0) begin
         Rt_Data = (RegWrite && (Rd_In == Rt_Addr)) ? WriteDataRegFile : regs_q[Rt_Addr];
      end
   end

   // Pending mask mirrors nonzero counters; counter 0 is never written so bit 0 stays low.
   always_comb begin
      for (int i = 0; i < int'(NREG); i++) begin
         Pending_Mask[i] = (cnt_q[i] != '0);
      end
   end

   // Register array, counters and sticky error; reset dominates, freeze holds everything.
   always_ff @(posedge clk) begin
      if (rest) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         sb_error_q <= 1'b0;
      end else if (!Freze) begin
         if (RegWrite && (Rd_In != 4'd0)) begin
            regs_q[Rd_In] <= WriteDataRegFile;
         end
         if (retire && (cnt_q[Rd_In] == '0)) begin
            sb_error_q <= 1'b1;
         end
         for (int i = 1; i < int'(NREG); i++) begin
            // Increment and decrement of one counter in the same cycle cancel out;
            // a decrement at zero is dropped (already flagged as an error above).
            if (accept && Issue_RegWrite && (Issue_Rd == 4'(i)) &&
                !(retire && (Rd_In == 4'(i)))) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (retire && (Rd_In == 4'(i)) && (cnt_q[i] != '0) &&
                         !(accept && Issue_RegWrite && (Issue_Rd == 4'(i)))) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios followed by
// random traffic, all compared against an integer-array reference model.
module tb_reg_file_scoreboard;

   logic        clk;
   logic        rest;
   logic        Freze;
   logic        RegWrite;
   logic [3:0]  Rd_In;
   logic [15:0] WriteDataRegFile;
   logic [3:0]  Rs_Addr;
   logic [3:0]  Rt_Addr;
   logic [15:0] Rs_Data;
   logic [15:0] Rt_Data;
   logic        Issue_Valid;
   logic        Issue_RegWrite;
   logic [3:0]  Issue_Rd;
   logic        Stall;
   logic [15:0] Pending_Mask;
   logic        Sb_Error;

   reg_file_scoreboard #(
      .NREG(16),
      .CNTW(3)
   ) dut (
      .clk              (clk),
      .rest             (rest),
      .Freze            (Freze),
      .RegWrite         (RegWrite),
      .Rd_In            (Rd_In),
      .WriteDataRegFile (WriteDataRegFile),
      .Rs_Addr          (Rs_Addr),
      .Rt_Addr          (Rt_Addr),
      .Rs_Data          (Rs_Data),
      .Rt_Data          (Rt_Data),
      .Issue_Valid      (Issue_Valid),
      .Issue_RegWrite   (Issue_RegWrite),
      .Issue_Rd         (Issue_Rd),
      .Stall            (Stall),
      .Pending_Mask     (Pending_Mask),
      .Sb_Error         (Sb_Error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int MaxCnt = 7;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain integers for registers, pending counts and the error flag.
   int m_reg [16];
   int m_cnt [16];
   int m_err;

   // Expected values for the current cycle, computed in sample() and reused in advance().
   bit e_stall;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_read(input int a);
      if (a == 0) return 0;
      if (RegWrite && int'(Rd_In) == a) return int'(WriteDataRegFile);
      return m_reg[a];
   endfunction

   function automatic bit m_retire();
      return RegWrite && !Freze && Rd_In != 0;
   endfunction

   function automatic bit m_busy(input int a);
      if (a == 0 || m_cnt[a] == 0) return 0;
      return !(m_retire() && int'(Rd_In) == a && m_cnt[a] == 1);
   endfunction

   // Compare every output against the model in the middle of the cycle.
   task automatic sample();
      int mask;
      bit full;
      @(negedge clk);
      mask = 0;
      for (int i = 1; i < 16; i++) if (m_cnt[i] > 0) mask += (1 << i);
      full = Issue_RegWrite && Issue_Rd != 0 && m_cnt[Issue_Rd] == MaxCnt &&
             !(m_retire() && Rd_In == Issue_Rd);
      e_stall = Issue_Valid && (m_busy(int'(Rs_Addr)) || m_busy(int'(Rt_Addr)) || full);
      check_eq("rs_data", 32'(Rs_Data), 32'(m_read(int'(Rs_Addr))));
      check_eq("rt_data", 32'(Rt_Data), 32'(m_read(int'(Rt_Addr))));
      check_eq("stall", 32'(Stall), 32'(e_stall));
      check_eq("pending_mask", 32'(Pending_Mask), 32'(mask));
      check_eq("sb_error", 32'(Sb_Error), 32'(m_err));
   endtask

   // Clock edge: apply the model's next-state rules, then step past the edge.
   task automatic advance();
      int old, nxt;
      bit inc, dec;
      @(posedge clk);
      if (rest) begin
         for (int i = 0; i < 16; i++) begin
            m_reg[i] = 0;
            m_cnt[i] = 0;
         end
         m_err = 0;
      end else if (!Freze) begin
         if (m_retire() && m_cnt[Rd_In] == 0) m_err = 1;
         for (int i = 1; i < 16; i++) begin
            old = m_cnt[i];
            inc = Issue_Valid && !e_stall && Issue_RegWrite && int'(Issue_Rd) == i;
            dec = m_retire() && int'(Rd_In) == i;
            nxt = old + int'(inc) - int'(dec);
            m_cnt[i] = (nxt < 0) ? 0 : nxt;
         end
         if (RegWrite && Rd_In != 0) m_reg[Rd_In] = int'(WriteDataRegFile);
      end
      #1;
   endtask

   task automatic idle();
      rest = 0; Freze = 0; RegWrite = 0; Rd_In = 0; WriteDataRegFile = 0;
      Rs_Addr = 0; Rt_Addr = 0; Issue_Valid = 0; Issue_RegWrite = 0; Issue_Rd = 0;
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_reg[i] = 0;
         m_cnt[i] = 0;
      end
      m_err = 0;
      idle();

      // Reset, then every output must be quiet for any issue.
      rest = 1; RegWrite = 1; Rd_In = 9; WriteDataRegFile = 16'h5555;
      Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 9;
      advance();
      idle();
      Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 9; Rs_Addr = 9; Rt_Addr = 3;
      sample();
      check_eq("reset_stall", 32'(Stall), 32'd0);
      check_eq("reset_mask", 32'(Pending_Mask), 32'd0);
      check_eq("reset_rs", 32'(Rs_Data), 32'd0);
      Issue_Valid = 0;
      advance();

      // Write-through bypass, then the array holds the value.
      idle(); RegWrite = 1; Rd_In = 3; WriteDataRegFile = 16'h1234; Rs_Addr = 3;
      sample();
      check_eq("bypass_rs", 32'(Rs_Data), 32'h1234);
      advance();
      RegWrite = 0;
      sample();
      check_eq("array_rs", 32'(Rs_Data), 32'h1234);
      advance();

      // Issue to R5, dependent stalls, retire clears it in the same cycle.
      idle(); Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 5;
      step();
      idle(); Issue_Valid = 1; Rs_Addr = 5;
      sample();
      check_eq("dep_stall", 32'(Stall), 32'd1);
      check_eq("dep_mask", 32'(Pending_Mask), 32'h0020);
      advance();
      RegWrite = 1; Rd_In = 5; WriteDataRegFile = 16'h0055;
      sample();
      check_eq("retire_unstall", 32'(Stall), 32'd0);
      advance();
      idle();
      sample();
      check_eq("retire_mask", 32'(Pending_Mask), 32'd0);
      advance();

      // Fill R2 to its limit; an extra issue stalls unless a retire frees a slot.
      idle(); Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 2;
      for (int k = 0; k < 7; k++) step();
      sample();
      check_eq("full_stall", 32'(Stall), 32'd1);
      advance();
      RegWrite = 1; Rd_In = 2; WriteDataRegFile = 16'h0002;
      sample();
      check_eq("full_retire_accept", 32'(Stall), 32'd0);
      advance();
      RegWrite = 0;
      sample();
      check_eq("still_full", 32'(Stall), 32'd1);
      advance();
      idle(); RegWrite = 1; Rd_In = 2; WriteDataRegFile = 16'h0022;
      for (int k = 0; k < 7; k++) step();
      idle();
      sample();
      check_eq("drained_mask", 32'(Pending_Mask), 32'd0);
      advance();

      // Freeze blocks state changes but reads and stall stay live.
      idle(); Freze = 1; RegWrite = 1; Rd_In = 4; WriteDataRegFile = 16'hBEEF; Rs_Addr = 4;
      Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 7;
      sample();
      check_eq("freeze_bypass", 32'(Rs_Data), 32'hBEEF);
      advance();
      idle(); Rs_Addr = 4;
      sample();
      check_eq("freeze_no_write", 32'(Rs_Data), 32'd0);
      check_eq("freeze_no_issue", 32'(Pending_Mask), 32'd0);
      advance();

      // Retire with nothing pending sets the sticky error; reset clears it.
      idle(); RegWrite = 1; Rd_In = 6; WriteDataRegFile = 16'h0006;
      step();
      idle();
      sample();
      check_eq("sb_err_set", 32'(Sb_Error), 32'd1);
      advance();
      sample();
      check_eq("sb_err_held", 32'(Sb_Error), 32'd1);
      advance();
      rest = 1;
      step();
      idle();
      sample();
      check_eq("sb_err_clear", 32'(Sb_Error), 32'd0);
      advance();

      // Writes to R0 are ignored and are not retires.
      idle(); RegWrite = 1; Rd_In = 0; WriteDataRegFile = 16'hFFFF; Rs_Addr = 0;
      sample();
      check_eq("r0_read", 32'(Rs_Data), 32'd0);
      advance();
      idle();
      sample();
      check_eq("r0_no_err", 32'(Sb_Error), 32'd0);
      advance();

      // Random traffic over a small address window to provoke hazards.
      for (int n = 0; n < 600; n++) begin
         rest             = ($urandom_range(63) == 0);
         Freze            = ($urandom_range(7) == 0);
         RegWrite         = $urandom_range(1);
         Rd_In            = 4'($urandom_range(7));
         WriteDataRegFile = 16'($urandom);
         Rs_Addr          = 4'($urandom_range(7));
         Rt_Addr          = 4'($urandom_range(7));
         Issue_Valid      = $urandom_range(1);
         Issue_RegWrite   = ($urandom_range(3) != 0);
         Issue_Rd         = 4'($urandom_range(7));
         // Keep clear of issue and spurious retire to the same empty counter in one cycle.
         if (m_retire() && m_cnt[Rd_In] == 0 && Issue_Rd == Rd_In) Issue_RegWrite = 0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
